gray_blur3x3: RTL and testbench
===============================

# gray_blur3x3

Streaming 3x3 spatial smoothing filter for the 8-bit luminance stream produced by the grayscale conversion stage. It sits directly downstream of that stage and upstream of the VGA output mux. It buffers two video lines internally and emits one filtered pixel per accepted input pixel, with fixed latency. Output pixels carry their own row/column tags so the display stage can blank out-of-range positions.

## Interface
- H_ACTIVE, 640, active pixels per line; sets line-buffer depth.
- V_ACTIVE, 480, active lines per frame.
- clk  input  1  pixel clock.
- rst  input  1  reset; asynchronous, active-high.
- i_gray  input  8  luminance of the current pixel.
- i_valid  input  1  i_gray/i_row/i_col qualify this cycle.
- i_row  input  13  row of the input pixel.
- i_col  input  13  column of the input pixel.
- o_gray  output  8  filtered luminance of the window centre.
- o_valid  output  1  o_gray/o_row/o_col qualify this cycle.
- o_row  output  13  row of the window centre.
- o_col  output  13  column of the window centre.

## Operation
- An input is accepted when i_valid=1, i_row<V_ACTIVE and i_col<H_ACTIVE. Any other input is ignored and treated as a gap.
- Line buffers: two H_ACTIVE x 8 RAMs addressed by i_col, with read-before-write semantics.
  - On each accepted pixel, LB1 reads line r-1 and LB0 reads line r-2.
  - The new pixel is written to LB1, and the old LB1 word is written to LB0.
- Window: a 3x3 register array. A new 3-pixel column shifts in only on accepted pixels, so gaps never disturb it.
- Centre: accepted input (r,c) completes the window centred on (r-1,c-1).
  - An output is produced only when r>=1 and c>=1.
  - The output frame therefore covers rows 0..V_ACTIVE-2 and cols 0..H_ACTIVE-2.
- Border: if centre row==0 or centre col==0, o_gray is the unfiltered centre pixel. The window there holds stale or previous-row data.
- Arithmetic:
  - Default kernel is [1 2 1; 2 4 2; 1 2 1].
  - The sum is at most 4080 and held in 12 bits.
  - o_gray = sum>>4 (truncation), so it never exceeds 255.
- Line-buffer contents are not reset. Frame start needs no special handling because row 0 is passed through.

## Timing
- Reset values: o_valid=0, o_gray=0, o_row=0, o_col=0; the window registers and pipeline valids are cleared. On assertion of rst these take effect immediately, without waiting for a clock edge.
- Pipeline:
  - S1: RAM read and window shift.
  - S2: kernel sum.
  - S3: output register.
- Latency: o_valid rises exactly 3 clk after the cycle in which the qualifying pixel (r,c) is accepted, tagged o_row=r-1, o_col=c-1.
- Throughput: one pixel per clock. Gaps in i_valid propagate as gaps on o_valid, with no change in latency or data.
- Reset mid-frame: in-flight pixels are discarded. Operation restarts cleanly on the next accepted pixel; the first post-reset row behaves as border-affected for any stale window data.
- A row change needs no flush. Centres at col -1 are not emitted, and centres at col 0 are border pass-through.

## Configuration
- Macro BLUR_GAUSS_EN.
- Defined: Gaussian kernel as above, o_gray = sum>>4.
- Undefined: box kernel (all weights 1).
  - 12-bit sum, at most 2295.
  - o_gray = (sum*57)>>9, using a 17-bit product.
  - Constant input v yields v for all v in 0..255.
- Border, latency and handshake are identical in both builds.

## Structure
- Package blur_pkg:
  - H_ACTIVE/V_ACTIVE defaults.
  - Coordinate width (13).
  - Kernel weights.
  - Box normalisation constants (57, shift 9).
  - Pipeline depth constant (3).
- Sub-module line_buffer: a simple dual-port, read-before-write RAM, parameterised by depth and width, instantiated twice.

## Test plan
- Constant frame of 100 (both builds) -> every o_valid pixel has o_gray=100; 479x639 outputs per frame.
- Impulse of 160 at (10,10) on a 0 background, Gaussian build:
  - Output (10,10)=40, (10,11)=20, (11,11)=10, (12,12)=0.
  - (10,10) appears 3 clk after input (11,11) is accepted.
- Border: input (0,5)=77 and (7,0)=200 -> outputs tagged (0,5)=77 and (7,0)=200, unfiltered.
- All-255 frame -> o_gray=255 everywhere with no wrap; in the box build every output is 255.
- Random i_valid gaps plus out-of-range coordinates (i_col=700) -> output sequence equals the gapless reference; each o_valid comes 3 clk after its qualifying input; out-of-range inputs produce nothing.
- rst pulsed mid-line -> o_valid=0 and o_gray=0 with no clock edge needed; no spurious o_valid before 3 clk after the next qualifying accepted pixel.

Source files
------------

// File: rtl/blur_pkg.sv
// Shared constants, kernel weights and normalisation for the 3x3 luminance blur.
// BLUR_GAUSS_EN selects the 1-2-1 Gaussian kernel; otherwise a box kernel is used.
package blur_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned COORD_W      = 13;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned SUM_W        = 12;
    localparam int unsigned PIPE_DEPTH   = 3;

    localparam int unsigned BOX_MUL      = 57;
    localparam int unsigned BOX_SHIFT    = 9;
    localparam int unsigned BOX_PROD_W   = 17;
    localparam int unsigned GAUSS_SHIFT  = 4;

`ifdef BLUR_GAUSS_EN
    localparam logic [2:0] KERNEL_W [3][3] = '{
        '{3'd1, 3'd2, 3'd1},
        '{3'd2, 3'd4, 3'd2},
        '{3'd1, 3'd2, 3'd1}
    };
`else
    localparam logic [2:0] KERNEL_W [3][3] = '{
        '{3'd1, 3'd1, 3'd1},
        '{3'd1, 3'd1, 3'd1},
        '{3'd1, 3'd1, 3'd1}
    };
`endif

    // Box build: 57/512 approximates 1/9 exactly enough that a flat field maps to itself.
    function automatic logic [PIX_W-1:0] blur_norm(input logic [SUM_W-1:0] sum);
`ifdef BLUR_GAUSS_EN
        return PIX_W'(sum >> GAUSS_SHIFT);
`else
        logic [BOX_PROD_W-1:0] prod;
        prod = BOX_PROD_W'(sum) * BOX_PROD_W'(BOX_MUL);
        return PIX_W'(prod >> BOX_SHIFT);
`endif
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Simple dual-port line RAM: synchronous write, asynchronous read, so a read and a
// write to the same address in one cycle return the old word (read-before-write).
module line_buffer #(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gray_blur3x3.sv
// Streaming 3x3 luminance smoothing filter with two line buffers and a 3-stage pipeline.
// Kernel is Gaussian when BLUR_GAUSS_EN is defined, box otherwise (see blur_pkg).
module gray_blur3x3
    import blur_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   i_gray,
    input  logic               i_valid,
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    output logic [PIX_W-1:0]   o_gray,
    output logic               o_valid,
    output logic [COORD_W-1:0] o_row,
    output logic [COORD_W-1:0] o_col
);

    localparam int unsigned ADDR_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    logic              accept;
    logic              emit;
    logic [ADDR_W-1:0] lb_addr;
    logic [PIX_W-1:0]  lb1_rd;
    logic [PIX_W-1:0]  lb0_rd;

    logic [PIX_W-1:0]      win_q [3][3];
    logic [PIX_W-1:0]      win_d [3][3];
    logic [PIPE_DEPTH-1:0] vld_q, vld_d;

    logic [COORD_W-1:0] s1_row_q, s1_row_d;
    logic [COORD_W-1:0] s1_col_q, s1_col_d;
    logic               s1_border_q, s1_border_d;

    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [PIX_W-1:0]   s2_centre_q, s2_centre_d;
    logic [COORD_W-1:0] s2_row_q, s2_row_d;
    logic [COORD_W-1:0] s2_col_q, s2_col_d;
    logic               s2_border_q, s2_border_d;

    logic [PIX_W-1:0]   o_gray_q, o_gray_d;
    logic [COORD_W-1:0] o_row_q, o_row_d;
    logic [COORD_W-1:0] o_col_q, o_col_d;

    always_comb begin
        accept  = i_valid && (i_row < COORD_W'(V_ACTIVE)) && (i_col < COORD_W'(H_ACTIVE));
        emit    = accept && (i_row != '0) && (i_col != '0);
        lb_addr = i_col[ADDR_W-1:0];
    end

    // LB1 holds line r-1; its displaced word cascades into LB0 as line r-2.
    line_buffer #(
        .DEPTH  (H_ACTIVE),
        .WIDTH  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_lb1 (
        .clk_i   (clk),
        .we_i    (accept),
        .waddr_i (lb_addr),
        .wdata_i (i_gray),
        .raddr_i (lb_addr),
        .rdata_o (lb1_rd)
    );

    line_buffer #(
        .DEPTH  (H_ACTIVE),
        .WIDTH  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_lb0 (
        .clk_i   (clk),
        .we_i    (accept),
        .waddr_i (lb_addr),
        .wdata_i (lb1_rd),
        .raddr_i (lb_addr),
        .rdata_o (lb0_rd)
    );

    // S1: window shift and centre tagging, only on accepted pixels.
    always_comb begin
        win_d       = win_q;
        s1_row_d    = s1_row_q;
        s1_col_d    = s1_col_q;
        s1_border_d = s1_border_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = i_gray;
            s1_row_d    = i_row - COORD_W'(1);
            s1_col_d    = i_col - COORD_W'(1);
            s1_border_d = (i_row == COORD_W'(1)) || (i_col == COORD_W'(1));
        end
        vld_d = {vld_q[PIPE_DEPTH-2:0], emit};
    end

    // S2: weighted kernel sum.
    always_comb begin
        sum_d       = sum_q;
        s2_centre_d = s2_centre_q;
        s2_row_d    = s2_row_q;
        s2_col_d    = s2_col_q;
        s2_border_d = s2_border_q;
        if (vld_q[0]) begin
            sum_d = '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    sum_d = sum_d + SUM_W'(win_q[r][c]) * SUM_W'(KERNEL_W[r][c]);
                end
            end
            s2_centre_d = win_q[1][1];
            s2_row_d    = s1_row_q;
            s2_col_d    = s1_col_q;
            s2_border_d = s1_border_q;
        end
    end

    // S3: normalise, or pass the centre through on row 0 / col 0.
    always_comb begin
        o_gray_d = o_gray_q;
        o_row_d  = o_row_q;
        o_col_d  = o_col_q;
        if (vld_q[1]) begin
            o_gray_d = s2_border_q ? s2_centre_q : blur_norm(sum_q);
            o_row_d  = s2_row_q;
            o_col_d  = s2_col_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q       <= '{default: '0};
            vld_q       <= '0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            s1_border_q <= 1'b0;
            sum_q       <= '0;
            s2_centre_q <= '0;
            s2_row_q    <= '0;
            s2_col_q    <= '0;
            s2_border_q <= 1'b0;
            o_gray_q    <= '0;
            o_row_q     <= '0;
            o_col_q     <= '0;
        end else begin
            win_q       <= win_d;
            vld_q       <= vld_d;
            s1_row_q    <= s1_row_d;
            s1_col_q    <= s1_col_d;
            s1_border_q <= s1_border_d;
            sum_q       <= sum_d;
            s2_centre_q <= s2_centre_d;
            s2_row_q    <= s2_row_d;
            s2_col_q    <= s2_col_d;
            s2_border_q <= s2_border_d;
            o_gray_q    <= o_gray_d;
            o_row_q     <= o_row_d;
            o_col_q     <= o_col_d;
        end
    end

    assign o_gray  = o_gray_q;
    assign o_valid = vld_q[PIPE_DEPTH-1];
    assign o_row   = o_row_q;
    assign o_col   = o_col_q;

endmodule

// File: tb/tb_gray_blur3x3.sv
// Scoreboard bench for gray_blur3x3 on a reduced 16x14 frame; expectations follow
// the kernel selected by BLUR_GAUSS_EN.
module tb_gray_blur3x3;

    localparam int H = 16;
    localparam int V = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  i_gray = '0;
    logic        i_valid = 1'b0;
    logic [12:0] i_row = '0;
    logic [12:0] i_col = '0;
    logic [7:0]  o_gray;
    logic        o_valid;
    logic [12:0] o_row;
    logic [12:0] o_col;

    always #5 clk = ~clk;

    gray_blur3x3 #(
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_gray  (i_gray),
        .i_valid (i_valid),
        .i_row   (i_row),
        .i_col   (i_col),
        .o_gray  (o_gray),
        .o_valid (o_valid),
        .o_row   (o_row),
        .o_col   (o_col)
    );

    typedef struct {
        logic [12:0] row;
        logic [12:0] col;
        logic [7:0]  gray;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  img [V][H];
    int          out_img [V][H];
    int          n_out;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_pix(input int r, input int c);
        int s;
        int w;
        if (r == 0 || c == 0) return img[r][c];
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
`ifdef BLUR_GAUSS_EN
                w = (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
`else
                w = 1;
`endif
                s += w * int'(img[r+dr][c+dc]);
            end
        end
`ifdef BLUR_GAUSS_EN
        return 8'(s >> 4);
`else
        return 8'((s * 57) >> 9);
`endif
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_o_valid actual_row=%0d actual_col=%0d required=none",
                         o_row, o_col);
            end else begin
                e = sb_q.pop_front();
                chk("o_row", int'(o_row), int'(e.row));
                chk("o_col", int'(o_col), int'(e.col));
                chk("o_gray", int'(o_gray), int'(e.gray));
                chk("latency_cycle", int'(cyc), int'(e.cyc));
                n_out++;
                if (int'(o_row) < V && int'(o_col) < H) out_img[o_row][o_col] = int'(o_gray);
            end
        end
    end

    task automatic drive_pix(input int r, input int c, input logic [7:0] g);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_row   = 13'(r);
        i_col   = 13'(c);
        i_gray  = g;
        if (r >= 1 && c >= 1) begin
            e.row  = 13'(r - 1);
            e.col  = 13'(c - 1);
            e.gray = ref_pix(r - 1, c - 1);
            e.cyc  = cyc + 3;
            sb_q.push_back(e);
        end
    endtask

    // Gap cycle: idle, column out of range, or row out of range.
    task automatic drive_idle(input int kind);
        @(posedge clk);
        #1;
        i_gray = 8'($urandom);
        i_row  = 13'($urandom_range(0, V - 1));
        i_col  = 13'($urandom_range(0, H - 1));
        case (kind)
            1:       begin i_valid = 1'b1; i_col = 13'd700; end
            2:       begin i_valid = 1'b1; i_row = 13'd700; end
            default: i_valid = 1'b0;
        endcase
    endtask

    task automatic clear_out();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) out_img[r][c] = -1;
        n_out = 0;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) img[r][c] = v;
    endtask

    task automatic fill_grad();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) img[r][c] = 8'(r * 17 + c * 5 + 3);
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if (gaps) repeat ($urandom_range(0, 2)) drive_idle($urandom_range(0, 2));
                drive_pix(r, c, img[r][c]);
            end
        end
        drive_idle(0);
    endtask

    task automatic drain_and_count(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        chk({name, "_drain"}, sb_q.size(), 0);
        chk({name, "_count"}, n_out, (V - 1) * (H - 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 rst = 1'b1;
        #1;
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_gray", int'(o_gray), 0);
        chk("rst_o_row", int'(o_row), 0);
        chk("rst_o_col", int'(o_col), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        fill(8'd100);
        clear_out();
        send_frame(1'b0);
        drain_and_count("const100");
        chk("const100_3_4", out_img[3][4], 100);

        fill(8'd0);
        img[10][10] = 8'd160;
        clear_out();
        send_frame(1'b0);
        drain_and_count("impulse");
`ifdef BLUR_GAUSS_EN
        chk("imp_10_10", out_img[10][10], 40);
        chk("imp_10_11", out_img[10][11], 20);
        chk("imp_11_11", out_img[11][11], 10);
        chk("imp_12_12", out_img[12][12], 0);
`else
        chk("imp_10_10", out_img[10][10], 17);
        chk("imp_10_11", out_img[10][11], 17);
        chk("imp_11_11", out_img[11][11], 17);
        chk("imp_12_12", out_img[12][12], 0);
`endif

        fill(8'd50);
        img[0][5] = 8'd77;
        img[7][0] = 8'd200;
        clear_out();
        send_frame(1'b0);
        drain_and_count("border");
        chk("border_0_5", out_img[0][5], 77);
        chk("border_7_0", out_img[7][0], 200);

        fill(8'd255);
        clear_out();
        send_frame(1'b0);
        drain_and_count("sat255");
        chk("sat255_5_5", out_img[5][5], 255);
        chk("sat255_0_0", out_img[0][0], 255);

        fill_grad();
        clear_out();
        send_frame(1'b1);
        drain_and_count("gaps");

        // Reset mid-line with the pipeline full.
        clear_out();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < H; c++) drive_pix(r, c, img[r][c]);
        for (int c = 0; c < 8; c++) drive_pix(4, c, img[4][c]);
        #2;
        chk("o_valid_before_rst", int'(o_valid), 1);
        rst     = 1'b1;
        i_valid = 1'b0;
        #1;
        chk("midrst_o_valid", int'(o_valid), 0);
        chk("midrst_o_gray", int'(o_gray), 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) drive_idle(0);
        clear_out();
        send_frame(1'b0);
        drain_and_count("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
